dla_ws_core: RTL and testbench
==============================

DLA_WS_CORE -- requirements
Module: dla_ws_core

Interface
REQ-001 SHALL have parameter ROWS, default 16: input channels per ifmap beat.
REQ-002 SHALL have parameter COLS, default 16: filters (output lanes).
REQ-003 SHALL have parameter DEPTH, default 4: maximum weight sets held, equal to the maximum cfg_k_steps.
REQ-004 SHALL have parameter AW, default 32: accumulator width; data width is fixed at 8 bits, signed.
REQ-005 SHALL have ports as follows (clock and reset first):
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  job request pulse.
- cfg_k_steps  in  3+  ($clog2(DEPTH)+1 bits) beats accumulated per output, 1..DEPTH.
- cfg_num_out  in  16  outputs per job, 1..65535.
- cfg_shift  in  5  requant right-shift.
- cfg_relu  in  1  clamp negatives to 0.
- cfg_mode  in  2  00 dense, 01 depthwise, 1x reserved.
- w_valid / w_ready  in / out  1  weight-beat handshake.
- w_data  in  COLS*ROWS*8  one weight set.
- if_valid / if_ready  in / out  1  ifmap-beat handshake.
- if_data  in  ROWS*8  one ifmap beat.
- out_valid / out_ready  out / in  1  result handshake.
- out_data  out  COLS*8  requantised results.
- out_last  out  1  marks the final output of the job.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at job completion.
- err  out  1  one-cycle pulse on rejected start.

Function
REQ-006 SHALL implement FSM states IDLE, LOAD_W, COMPUTE, OUT.
REQ-007 SHALL, in IDLE, on start, register all cfg_* inputs and go to LOAD_W; cfg_* inputs SHALL be ignored at all other times.
REQ-008 SHALL reject a start with cfg_k_steps==0, cfg_k_steps>DEPTH, cfg_num_out==0, or cfg_mode[1]==1: pulse err for one cycle and stay in IDLE.
REQ-009 SHALL ignore start outside IDLE: no err pulse, no effect.
REQ-010 SHALL drive w_ready=1 only in LOAD_W; handshake i SHALL write weight buffer entry i; after cfg_k_steps handshakes it SHALL go to COMPUTE.
REQ-011 SHALL drive if_ready=1 only in COMPUTE; ifmap beat j (0..k-1) SHALL be multiplied with weight set j.
REQ-012 SHALL, in dense mode, compute acc[c] += sum over r of w[j][c][r]*if[r], using signed 8x8 products and sign extension to AW.
REQ-013 SHALL, in depthwise mode, compute acc[c] += w[j][c][c]*if[c]; this mode requires ROWS==COLS, which SHALL be checked by an elaboration-time assertion.
REQ-014 SHALL, on the handshake of beat k-1, go to OUT; out_valid SHALL rise exactly 2 rising edges after that handshake edge, with out_data registered.
REQ-015 SHALL requantise each lane as follows:
- if shift>0, add 1<<(shift-1);
- arithmetic right shift by cfg_shift;
- saturate to [-128,127];
- if cfg_relu, map negative values to 0.
REQ-016 SHALL hold out_valid, out_data and out_last stable until out_ready; on that handshake it SHALL clear all accumulators and the beat counter.
REQ-017 SHALL, on the output handshake, return to COMPUTE if outputs remain; otherwise pulse done in the same cycle and go to IDLE.
REQ-018 SHALL keep weights stationary: the buffer is reused for all cfg_num_out outputs of the job.
REQ-019 SHALL assert out_last with the output whose index equals cfg_num_out-1.
REQ-020 SHALL handle edge cases as follows:
- k_steps==1: every beat produces an output.
- Outputs counter SHALL not wrap at 65535.
- w_valid and if_valid asserted simultaneously: only the port whose ready is high is consumed.

Reset
REQ-021 SHALL, on rst low, immediately go to IDLE and clear all of the following to 0: out_valid, out_last, out_data, w_ready, if_ready, busy, done, err, accumulators, counters.
REQ-022 SHALL leave the weight buffer unreset; its contents are undefined until the next LOAD_W.
REQ-023 SHALL, on reset mid-job, abandon the job with no done pulse; after rst is released the block accepts a new start on the first clock edge.

Structure
REQ-024 SHALL place the following in shared package dla_pkg: state enum, mode enum (DENSE, DEPTHWISE), and parameter defaults.
REQ-025 SHALL instantiate sub-module dla_pe_col COLS times; each instance holds one column's dot-product, accumulator and requant/saturate logic.

Verification
REQ-026 SHALL cover dense, k=1, shift=0, no relu: all weights 1, if all 2 -> every lane 32 (ROWS=16), with out_valid at handshake+2.
REQ-027 SHALL cover k=3, num_out=2: three weight beats, six ifmap beats -> exactly 2 outputs, out_last on the second, done pulse on its handshake.
REQ-028 SHALL cover saturation and relu:
- Products giving a sum of 1000 with shift=2 -> 127 (round(250) saturates).
- A sum of -1000 with relu=1 -> 0.
REQ-029 SHALL cover depthwise: w[c][c]=c, if[c]=1, other weights 5 -> lane c outputs c.
REQ-030 SHALL cover out_ready held low 10 cycles: out_data stable, if_ready=0, no beat consumed; start with k=0 or k=DEPTH+1 -> err pulse, busy stays 0.
REQ-031 SHALL cover rst asserted during COMPUTE: all outputs 0 asynchronously; a new job after release produces correct results with no stale accumulation.

Source files
------------

// File: rtl/dla_pkg.sv
// Shared types and default geometry for the weight-stationary DLA core.
package dla_pkg;

    localparam int DLA_ROWS  = 16;
    localparam int DLA_COLS  = 16;
    localparam int DLA_DEPTH = 4;
    localparam int DLA_AW    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        OUT     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        DENSE     = 2'd0,
        DEPTHWISE = 2'd1
    } mode_e;

endpackage

// File: rtl/dla_pe_col.sv
// One output column: signed dot-product, accumulator and requantisation stage.
module dla_pe_col
    import dla_pkg::*;
#(
    parameter int ROWS    = DLA_ROWS,
    parameter int AW      = DLA_AW,
    parameter int COL_IDX = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [4:0]          shift,
    input  logic                relu,
    input  logic [ROWS*8-1:0]   w_col,
    input  logic [ROWS*8-1:0]   if_data,
    output logic [7:0]          q
);

    localparam int DW = COL_IDX % ROWS;
    localparam logic signed [AW:0] SAT_HI = (AW+1)'(127);
    localparam logic signed [AW:0] SAT_LO = (AW+1)'(-128);

    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] dot_s;
    logic signed [15:0]   prod_s;

    // Round half-up, arithmetic shift, saturate to int8, optional ReLU.
    function automatic logic [7:0] requant(input logic signed [AW-1:0] v,
                                           input logic [4:0] sh,
                                           input logic rl);
        logic signed [AW:0] x;
        logic signed [AW:0] rnd;
        logic [7:0]         sat;
        if (sh != 5'd0) rnd = {{AW{1'b0}}, 1'b1} << (sh - 5'd1);
        else            rnd = {(AW+1){1'b0}};
        x = (AW+1)'(v) + rnd;
        x = x >>> sh;
        if (x > SAT_HI)      sat = 8'h7f;
        else if (x < SAT_LO) sat = 8'h80;
        else                 sat = x[7:0];
        if (rl && sat[7]) sat = 8'h00;
        else              sat = sat;
        return sat;
    endfunction

    // Per-beat contribution: full dot-product, or only the diagonal in depthwise mode.
    always_comb begin
        dot_s  = {AW{1'b0}};
        prod_s = 16'sd0;
        if (mode == DEPTHWISE) begin
            prod_s = 16'($signed(w_col[DW*8 +: 8])) * 16'($signed(if_data[DW*8 +: 8]));
            dot_s  = {{(AW-16){prod_s[15]}}, prod_s};
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                prod_s = 16'($signed(w_col[r*8 +: 8])) * 16'($signed(if_data[r*8 +: 8]));
                dot_s  = dot_s + {{(AW-16){prod_s[15]}}, prod_s};
            end
        end
    end

    // Accumulator plus a free-running requantised copy one cycle behind it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {AW{1'b0}};
            q     <= 8'h00;
        end else begin
            if (clr)     acc_r <= {AW{1'b0}};
            else if (en) acc_r <= acc_r + dot_s;
            q <= requant(acc_r, shift, relu);
        end
    end

endmodule

// File: rtl/dla_ws_core.sv
// Weight-stationary DLA core. w_data byte (c*ROWS + r) is the weight of filter c,
// input channel r; if_data byte r is channel r; out_data byte c is lane c.
module dla_ws_core
    import dla_pkg::*;
#(
    parameter int ROWS  = DLA_ROWS,
    parameter int COLS  = DLA_COLS,
    parameter int DEPTH = DLA_DEPTH,
    parameter int AW    = DLA_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     cfg_k_steps,
    input  logic [15:0]                cfg_num_out,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_relu,
    input  logic [1:0]                 cfg_mode,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*ROWS*8-1:0]     w_data,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [ROWS*8-1:0]          if_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*8-1:0]          out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int KW = $clog2(DEPTH) + 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_LOAD_W  = LOAD_W;
    localparam logic [1:0] ST_COMPUTE = COMPUTE;
    localparam logic [1:0] ST_OUT     = OUT;

    if (ROWS != COLS) begin : g_dw_geom
        $error("dla_ws_core: depthwise mode requires ROWS == COLS");
    end

    logic [1:0]              state_r, nxt_s, ph_r;
    logic [KW-1:0]           k_r, w_cnt_r, beat_cnt_r, k_last_s;
    logic [15:0]             num_out_r, out_cnt_r;
    logic [4:0]              shift_r;
    logic                    relu_r;
    logic [1:0]              mode_r;
    logic [COLS*ROWS*8-1:0]  wbuf [DEPTH];
    logic [COLS*ROWS*8-1:0]  wsel_s;
    logic [COLS*8-1:0]       q_s;
    logic cfg_ok_s, accept_s, w_fire_s, if_fire_s, o_fire_s;
    logic is_last_s, last_w_s, last_beat_s;

    assign cfg_ok_s    = (cfg_k_steps != {KW{1'b0}}) && (cfg_k_steps <= KW'(DEPTH)) &&
                         (cfg_num_out != 16'd0) && !cfg_mode[1];
    assign accept_s    = (state_r == ST_IDLE) && start && cfg_ok_s;
    assign w_fire_s    = w_valid & w_ready;
    assign if_fire_s   = if_valid & if_ready;
    assign o_fire_s    = out_valid & out_ready;
    assign k_last_s    = k_r - KW'(1);
    assign last_w_s    = w_fire_s && (w_cnt_r == k_last_s);
    assign last_beat_s = if_fire_s && (beat_cnt_r == k_last_s);
    assign is_last_s   = (out_cnt_r == (num_out_r - 16'd1));
    assign wsel_s      = wbuf[beat_cnt_r[IW-1:0]];

    // Next-state selection.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_IDLE:    if (accept_s) nxt_s = ST_LOAD_W; else nxt_s = ST_IDLE;
            ST_LOAD_W:  if (last_w_s) nxt_s = ST_COMPUTE; else nxt_s = ST_LOAD_W;
            ST_COMPUTE: if (last_beat_s) nxt_s = ST_OUT; else nxt_s = ST_COMPUTE;
            ST_OUT: begin
                if (o_fire_s) begin
                    if (is_last_s) nxt_s = ST_IDLE;
                    else           nxt_s = ST_COMPUTE;
                end else begin
                    nxt_s = ST_OUT;
                end
            end
            default:    nxt_s = ST_IDLE;
        endcase
    end

    // Control state, counters, job config and the registered output stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            ph_r       <= 2'd0;
            k_r        <= {KW{1'b0}};
            w_cnt_r    <= {KW{1'b0}};
            beat_cnt_r <= {KW{1'b0}};
            num_out_r  <= 16'd0;
            out_cnt_r  <= 16'd0;
            shift_r    <= 5'd0;
            relu_r     <= 1'b0;
            mode_r     <= 2'd0;
            w_ready    <= 1'b0;
            if_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= {(COLS*8){1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r  <= nxt_s;
            busy     <= (nxt_s != ST_IDLE);
            w_ready  <= (nxt_s == ST_LOAD_W);
            if_ready <= (nxt_s == ST_COMPUTE);
            err      <= (state_r == ST_IDLE) && start && !cfg_ok_s;
            done     <= o_fire_s && is_last_s;
            if (accept_s) begin
                k_r       <= cfg_k_steps;
                num_out_r <= cfg_num_out;
                shift_r   <= cfg_shift;
                relu_r    <= cfg_relu;
                mode_r    <= cfg_mode;
            end
            if (accept_s)      w_cnt_r <= {KW{1'b0}};
            else if (w_fire_s) w_cnt_r <= w_cnt_r + KW'(1);
            if (accept_s || o_fire_s) beat_cnt_r <= {KW{1'b0}};
            else if (if_fire_s)       beat_cnt_r <= beat_cnt_r + KW'(1);
            if (accept_s)      out_cnt_r <= 16'd0;
            else if (o_fire_s) out_cnt_r <= out_cnt_r + 16'd1;
            // Two edges after the last beat: one for the PE requant stage, one here.
            if (last_beat_s) begin
                ph_r <= 2'd0;
            end else if (state_r == ST_OUT && ph_r == 2'd0) begin
                ph_r <= 2'd1;
            end else if (state_r == ST_OUT && ph_r == 2'd1) begin
                ph_r      <= 2'd2;
                out_valid <= 1'b1;
                out_data  <= q_s;
                out_last  <= is_last_s;
            end
            if (o_fire_s) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

    // Weight buffer: deliberately unreset, rewritten on every LOAD_W.
    always_ff @(posedge clk) begin
        if (w_fire_s) wbuf[w_cnt_r[IW-1:0]] <= w_data;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        dla_pe_col #(.ROWS(ROWS), .AW(AW), .COL_IDX(c)) u_pe (
            .clk     (clk),
            .rst     (rst),
            .clr     (o_fire_s | accept_s),
            .en      (if_fire_s),
            .mode    (mode_r),
            .shift   (shift_r),
            .relu    (relu_r),
            .w_col   (wsel_s[c*ROWS*8 +: ROWS*8]),
            .if_data (if_data),
            .q       (q_s[c*8 +: 8])
        );
    end

endmodule

// File: tb/tb_dla_ws_core.sv
// Directed self-checking bench for dla_ws_core (ROWS=COLS=16, DEPTH=4).
module tb_dla_ws_core;
    import dla_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    cfg_k_steps = 3'd0;
    logic [15:0]   cfg_num_out = 16'd0;
    logic [4:0]    cfg_shift = 5'd0;
    logic          cfg_relu = 1'b0;
    logic [1:0]    cfg_mode = 2'd0;
    logic          w_valid = 1'b0;
    logic          w_ready;
    logic [2047:0] w_data = '0;
    logic          if_valid = 1'b0;
    logic          if_ready;
    logic [127:0]  if_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  out_data;
    logic          out_last;
    logic          busy, done, err;

    int total = 0;
    int passed = 0;

    dla_ws_core #(.ROWS(16), .COLS(16), .DEPTH(4), .AW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k_steps(cfg_k_steps),
        .cfg_num_out(cfg_num_out), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .cfg_mode(cfg_mode), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic chk_d(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2047:0] w_fill(input logic [7:0] b);
        return {256{b}};
    endfunction

    function automatic logic [127:0] v_fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic start_job(input logic [2:0] k, input logic [15:0] n, input logic [4:0] sh,
                             input logic rl, input logic [1:0] md);
        cfg_k_steps = k; cfg_num_out = n; cfg_shift = sh; cfg_relu = rl; cfg_mode = md;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_w(input logic [2047:0] d, input string tag);
        int n = 0;
        w_data = d; w_valid = 1'b1;
        while (!w_ready && n < 20) begin step(); n++; end
        chk(tag, w_ready, 1'b1);
        step();
        w_valid = 1'b0;
    endtask

    task automatic send_if(input logic [127:0] d, input string tag);
        int n = 0;
        if_data = d; if_valid = 1'b1;
        while (!if_ready && n < 20) begin step(); n++; end
        chk(tag, if_ready, 1'b1);
        step();
        if_valid = 1'b0;
    endtask

    task automatic get_out(input string tag, output logic [127:0] d, output logic l);
        int n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk(tag, out_valid, 1'b1);
        d = out_data;
        l = out_last;
        step();
    endtask

    initial begin
        logic [127:0]  d, e;
        logic          l;
        logic [2047:0] wv;
        int            n;

        // Asynchronous reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);       chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_if_ready", if_ready, 1'b0); chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0); chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);          chk_d("rst_out_data", out_data, 128'd0);
        @(negedge clk) rst = 1'b1;

        // Dense k=1: ones x twos -> 32 per lane, out_valid two edges after the beat
        start_job(3'd1, 16'd1, 5'd0, 1'b0, DENSE);
        chk("a_busy", busy, 1'b1); chk("a_w_ready", w_ready, 1'b1); chk("a_err", err, 1'b0);
        send_w(w_fill(8'd1), "a_w");
        chk("a_w_ready_low", w_ready, 1'b0); chk("a_if_ready", if_ready, 1'b1);
        send_if(v_fill(8'd2), "a_if");
        chk("a_lat0", out_valid, 1'b0);
        step(); chk("a_lat1", out_valid, 1'b0);
        step(); chk("a_lat2", out_valid, 1'b1);
        chk_d("a_data", out_data, v_fill(8'd32)); chk("a_last", out_last, 1'b1);
        step();
        chk("a_done", done, 1'b1); chk("a_busy_end", busy, 1'b0); chk("a_ov_end", out_valid, 1'b0);
        step(); chk("a_done_pulse", done, 1'b0);

        // k=3, two outputs; w_valid held high during compute must not be consumed
        start_job(3'd3, 16'd2, 5'd0, 1'b0, DENSE);
        send_w(w_fill(8'd1), "b_w0"); send_w(w_fill(8'd2), "b_w1"); send_w(w_fill(8'd3), "b_w2");
        w_valid = 1'b1; w_data = w_fill(8'h7f);
        chk("b_if_ready", if_ready, 1'b1); chk("b_w_ready", w_ready, 1'b0);
        send_if(v_fill(8'd1), "b_if0"); send_if(v_fill(8'd1), "b_if1"); send_if(v_fill(8'd1), "b_if2");
        get_out("b_v0", d, l);
        chk_d("b_data0", d, v_fill(8'd96)); chk("b_last0", l, 1'b0);
        chk("b_done0", done, 1'b0); chk("b_busy0", busy, 1'b1);
        send_if(v_fill(8'd2), "b_if3"); send_if(v_fill(8'd0), "b_if4"); send_if(v_fill(8'd1), "b_if5");
        get_out("b_v1", d, l);
        chk_d("b_data1", d, v_fill(8'd80)); chk("b_last1", l, 1'b1); chk("b_done1", done, 1'b1);
        w_valid = 1'b0;

        // Saturation (+1000 >> 2 -> 127) and ReLU (-1000 -> 0)
        start_job(3'd1, 16'd2, 5'd2, 1'b1, DENSE);
        send_w(w_fill(8'd1), "c_w");
        send_if({{15{8'd62}}, 8'd70}, "c_if0");
        get_out("c_v0", d, l); chk_d("c_sat_hi", d, v_fill(8'd127));
        send_if({{15{8'hc2}}, 8'hba}, "c_if1");
        get_out("c_v1", d, l); chk_d("c_relu", d, v_fill(8'd0)); chk("c_last", l, 1'b1);
        start_job(3'd1, 16'd1, 5'd2, 1'b0, DENSE);
        send_w(w_fill(8'd1), "c_w2");
        send_if({{15{8'hc2}}, 8'hba}, "c_if2");
        get_out("c_v2", d, l); chk_d("c_sat_lo", d, v_fill(8'h80)); chk("c_done", done, 1'b1);

        // Rounding with distinct per-column weights: lane c = round(+-3c / 2)
        wv = '0;
        for (int c = 0; c < 16; c++) wv[c*128 +: 8] = 8'(c);
        start_job(3'd1, 16'd2, 5'd1, 1'b0, DENSE);
        send_w(wv, "d_w");
        send_if({{15{8'd0}}, 8'd3}, "d_if0");
        for (int c = 0; c < 16; c++) e[c*8 +: 8] = 8'((3*c + 1) >>> 1);
        get_out("d_v0", d, l); chk_d("d_round_pos", d, e);
        send_if({{15{8'd0}}, 8'hfd}, "d_if1");
        for (int c = 0; c < 16; c++) e[c*8 +: 8] = 8'((1 - 3*c) >>> 1);
        get_out("d_v1", d, l); chk_d("d_round_neg", d, e);

        // Depthwise: diagonal weight c, off-diagonal 5, ifmap ones -> lane c = c
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 16; r++)
                wv[(c*16 + r)*8 +: 8] = (r == c) ? 8'(c) : 8'd5;
        for (int c = 0; c < 16; c++) e[c*8 +: 8] = 8'(c);
        start_job(3'd1, 16'd1, 5'd0, 1'b0, DEPTHWISE);
        send_w(wv, "e_w");
        send_if(v_fill(8'd1), "e_if");
        get_out("e_v", d, l); chk_d("e_dw", d, e); chk("e_last", l, 1'b1);

        // Output stall for 10 cycles with a pending ifmap beat
        start_job(3'd1, 16'd2, 5'd0, 1'b0, DENSE);
        send_w(w_fill(8'd1), "f_w");
        out_ready = 1'b0;
        send_if(v_fill(8'd1), "f_if0");
        if_valid = 1'b1; if_data = v_fill(8'd3);
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        chk("f_valid", out_valid, 1'b1);
        repeat (10) begin
            step();
            chk("f_hold_valid", out_valid, 1'b1);
            chk_d("f_hold_data", out_data, v_fill(8'd16));
            chk("f_hold_if_ready", if_ready, 1'b0);
        end
        out_ready = 1'b1;
        step();
        chk("f_done0", done, 1'b0); chk("f_busy", busy, 1'b1);
        send_if(v_fill(8'd3), "f_if1");
        get_out("f_v1", d, l);
        chk_d("f_data1", d, v_fill(8'd48)); chk("f_last", l, 1'b1); chk("f_done1", done, 1'b1);

        // Rejected starts
        start_job(3'd0, 16'd1, 5'd0, 1'b0, DENSE);
        chk("g_err_k0", err, 1'b1); chk("g_busy_k0", busy, 1'b0);
        step(); chk("g_err_pulse", err, 1'b0);
        start_job(3'd5, 16'd1, 5'd0, 1'b0, DENSE);
        chk("g_err_k5", err, 1'b1); chk("g_busy_k5", busy, 1'b0);
        start_job(3'd1, 16'd0, 5'd0, 1'b0, DENSE);
        chk("g_err_n0", err, 1'b1);
        start_job(3'd1, 16'd1, 5'd0, 1'b0, 2'b10);
        chk("g_err_mode", err, 1'b1); chk("g_busy_mode", busy, 1'b0);

        // Start outside IDLE is ignored, config unchanged
        start_job(3'd1, 16'd1, 5'd0, 1'b0, DENSE);
        start_job(3'd0, 16'd0, 5'd3, 1'b1, 2'b10);
        chk("h_no_err", err, 1'b0); chk("h_w_ready", w_ready, 1'b1);
        send_w(w_fill(8'd1), "h_w");
        send_if(v_fill(8'd1), "h_if");
        get_out("h_v", d, l); chk_d("h_data", d, v_fill(8'd16)); chk("h_done", done, 1'b1);

        // Reset during COMPUTE, then a clean job with no stale accumulation
        start_job(3'd2, 16'd1, 5'd0, 1'b0, DENSE);
        send_w(w_fill(8'd1), "i_w0"); send_w(w_fill(8'd1), "i_w1");
        send_if(v_fill(8'd4), "i_if0");
        #2 rst = 1'b0;
        #1;
        chk("i_busy", busy, 1'b0); chk("i_if_ready", if_ready, 1'b0);
        chk("i_w_ready", w_ready, 1'b0); chk("i_ov", out_valid, 1'b0);
        chk("i_done", done, 1'b0); chk_d("i_data", out_data, 128'd0);
        @(negedge clk) rst = 1'b1;
        start_job(3'd1, 16'd1, 5'd0, 1'b0, DENSE);
        chk("i_busy2", busy, 1'b1);
        send_w(w_fill(8'd1), "i_w2");
        send_if(v_fill(8'd1), "i_if1");
        get_out("i_v", d, l);
        chk_d("i_fresh", d, v_fill(8'd16)); chk("i_last", l, 1'b1); chk("i_done2", done, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
